// File: rtl/mips_defs.sv
// Shared definitions for the MIPS fetch path: jump-select encodings,
// the NOP word and the default reset PC.
package mips_defs;

  localparam logic [1:0]  JMP_SEQ = 2'b00;
  localparam logic [1:0]  JMP_IMM = 2'b01;
  localparam logic [1:0]  JMP_REG = 2'b10;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, branch offset, pseudo-direct
// J/JAL target and register target. All adds wrap silently at 2^32.
module npc_calc
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] d_pc,
  input  logic [1:0]  jump,
  input  logic        pcex_op,
  input  logic [25:0] d_imm26,
  input  logic [31:0] rs_value,
  output logic [31:0] npc
);

  logic        [31:0] pc_plus4;
  logic        [31:0] d_pc_plus4;
  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  assign pc_plus4   = pc + 32'd4;
  assign d_pc_plus4 = d_pc + 32'd4;
  // Branch offsets are relative to the delay-slot address (d_pc + 4).
  assign br_off     = {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
  assign br_target  = d_pc_plus4 + br_off;
  assign j_target   = {d_pc_plus4[31:28], d_imm26, 2'b00};

  // Select the next fetch address; the reserved encoding falls back to sequential.
  always_comb begin
    npc = pc_plus4;
    case (jump)
      JMP_IMM: npc = pcex_op ? j_target : br_target;
      JMP_REG: npc = rs_value;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_npc_unit.sv
// F-stage PC engine: PC register, fetch-fault check and the IF/ID pipeline
// register. Redirects from D take effect on the following fetch, so the
// instruction already in F becomes the single delay slot.
module fetch_npc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_clear,
  input  logic [1:0]  jump,
  input  logic        pcex_op,
  input  logic [25:0] d_imm26,
  input  logic [31:0] rs_value,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_fetch_fault
);

  // Range bounds carried in 33 bits so the upper limit cannot wrap.
  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = PC_LO + 33'(4 * IMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] pc8;
  logic        fault;

  npc_calc u_npc_calc (
    .pc       (pc),
    .d_pc     (d_pc),
    .jump     (jump),
    .pcex_op  (pcex_op),
    .d_imm26  (d_imm26),
    .rs_value (rs_value),
    .npc      (npc)
  );

  assign imem_addr = pc;
  assign pc8       = pc + 32'd8;

  // Flag fetches from a misaligned or out-of-range PC.
  always_comb begin
    fault = 1'b0;
    if ((pc[1:0] != 2'b00) || ({1'b0, pc} < PC_LO) || ({1'b0, pc} >= PC_HI))
      fault = 1'b1;
  end

  // ---- F -> D stage boundary: PC advance and IF/ID capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      d_instr       <= NOP;
      d_pc          <= RESET_PC;
      d_pc8         <= RESET_PC + 32'd8;
      d_fetch_fault <= 1'b0;
    end else if (!stall) begin
      pc    <= npc;
      d_pc  <= pc;
      d_pc8 <= pc8;
      if (id_clear) begin
        d_instr       <= NOP;
        d_fetch_fault <= 1'b0;
      end else begin
        d_instr       <= fault ? NOP : imem_rdata;
        d_fetch_fault <= fault;
      end
    end
  end

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed bench for fetch_npc_unit. Each step queues the state expected
// after the next rising edge; the tick task pops and checks it.
module tb_fetch_npc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        id_clear;
  logic [1:0]  jump;
  logic        pcex_op;
  logic [25:0] d_imm26;
  logic [31:0] rs_value;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_fetch_fault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_npc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .id_clear      (id_clear),
    .jump          (jump),
    .pcex_op       (pcex_op),
    .d_imm26       (d_imm26),
    .rs_value      (rs_value),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .d_instr       (d_instr),
    .d_pc          (d_pc),
    .d_pc8         (d_pc8),
    .d_fetch_fault (d_fetch_fault)
  );

  // ROM image: every word is tagged with its own address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = rom(imem_addr);

  task automatic expect_next(input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] p, input logic [31:0] p8,
                             input logic f);
    exp_t e;
    e.addr = a; e.instr = i; e.pc = p; e.pc8 = p8; e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk32({tag, "_addr"},  imem_addr, e.addr);
      chk32({tag, "_instr"}, d_instr,   e.instr);
      chk32({tag, "_pc"},    d_pc,      e.pc);
      chk32({tag, "_pc8"},   d_pc8,     e.pc8);
      chk32({tag, "_fault"}, {31'd0, d_fetch_fault}, {31'd0, e.fault});
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; id_clear = 1'b0; jump = 2'b00;
    pcex_op = 1'b0; d_imm26 = 26'd0; rs_value = 32'd0;

    // Reset state
    expect_next(32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0); tick("rst0");
    expect_next(32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0); tick("rst1");
    reset = 1'b0;

    // Free-running sequential fetch
    expect_next(32'h3004, rom(32'h3000), 32'h3000, 32'h3008, 1'b0); tick("seq0");
    expect_next(32'h3008, rom(32'h3004), 32'h3004, 32'h300C, 1'b0); tick("seq1");
    expect_next(32'h300C, rom(32'h3008), 32'h3008, 32'h3010, 1'b0); tick("seq2");
    expect_next(32'h3010, rom(32'h300C), 32'h300C, 32'h3014, 1'b0); tick("seq3");
    expect_next(32'h3014, rom(32'h3010), 32'h3010, 32'h3018, 1'b0); tick("seq4");

    // Taken branch from d_pc=0x3010, offset -4 words
    jump = 2'b01; pcex_op = 1'b0; d_imm26 = 26'h000FFFC;
    expect_next(32'h3004, rom(32'h3014), 32'h3014, 32'h301C, 1'b0); tick("beq");
    jump = 2'b00;
    expect_next(32'h3008, rom(32'h3004), 32'h3004, 32'h300C, 1'b0); tick("beq_tgt");

    // Walk forward until d_pc = 0x3020
    for (int a = 32'h3008; a <= 32'h3020; a += 4)
      begin
        expect_next(a + 4, rom(a), a, a + 8, 1'b0);
        tick("walk");
      end

    // JAL pseudo-direct target
    jump = 2'b01; pcex_op = 1'b1; d_imm26 = 26'h0000C40;
    expect_next(32'h3100, rom(32'h3024), 32'h3024, 32'h302C, 1'b0); tick("jal");
    jump = 2'b00; pcex_op = 1'b0;
    expect_next(32'h3104, rom(32'h3100), 32'h3100, 32'h3108, 1'b0); tick("jal_tgt");

    // JR to a misaligned address
    jump = 2'b10; rs_value = 32'h3002;
    expect_next(32'h3002, rom(32'h3104), 32'h3104, 32'h310C, 1'b0); tick("jr");
    jump = 2'b00;
    expect_next(32'h3006, 32'h0, 32'h3002, 32'h300A, 1'b1); tick("jr_misal");
    jump = 2'b10; rs_value = 32'h3040;
    expect_next(32'h3040, 32'h0, 32'h3006, 32'h300E, 1'b1); tick("jr_rec");
    jump = 2'b00;
    expect_next(32'h3044, rom(32'h3040), 32'h3040, 32'h3048, 1'b0); tick("jr_ok");

    // Range boundaries: last legal word, just below base, just past the top
    jump = 2'b10; rs_value = 32'h6FFC;
    expect_next(32'h6FFC, rom(32'h3044), 32'h3044, 32'h304C, 1'b0); tick("hi_set");
    rs_value = 32'h2FFC;
    expect_next(32'h2FFC, rom(32'h6FFC), 32'h6FFC, 32'h7004, 1'b0); tick("hi_last");
    jump = 2'b00;
    expect_next(32'h3000, 32'h0, 32'h2FFC, 32'h3004, 1'b1); tick("lo_fault");
    jump = 2'b10; rs_value = 32'h7000;
    expect_next(32'h7000, rom(32'h3000), 32'h3000, 32'h3008, 1'b0); tick("hi_jump");
    rs_value = 32'h3050;
    expect_next(32'h3050, 32'h0, 32'h7000, 32'h7008, 1'b1); tick("hi_fault");
    jump = 2'b11;
    expect_next(32'h3054, rom(32'h3050), 32'h3050, 32'h3058, 1'b0); tick("rsv_seq");
    jump = 2'b00;
    expect_next(32'h3058, rom(32'h3054), 32'h3054, 32'h305C, 1'b0); tick("seq5");

    // Stall holds everything even with a redirect requested
    stall = 1'b1; jump = 2'b01; pcex_op = 1'b1; d_imm26 = 26'h0000C40;
    expect_next(32'h3058, rom(32'h3054), 32'h3054, 32'h305C, 1'b0); tick("stall0");
    expect_next(32'h3058, rom(32'h3054), 32'h3054, 32'h305C, 1'b0); tick("stall1");
    stall = 1'b0; jump = 2'b00; pcex_op = 1'b0; id_clear = 1'b1;
    expect_next(32'h305C, 32'h0, 32'h3058, 32'h3060, 1'b0); tick("clear");
    id_clear = 1'b0;
    expect_next(32'h3060, rom(32'h305C), 32'h305C, 32'h3064, 1'b0); tick("seq6");
    stall = 1'b1; id_clear = 1'b1;
    expect_next(32'h3060, rom(32'h305C), 32'h305C, 32'h3064, 1'b0); tick("stall_clr");

    // Reset overrides stall and id_clear
    reset = 1'b1;
    expect_next(32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0); tick("rst_mid");
    reset = 1'b0; stall = 1'b0; id_clear = 1'b0;
    expect_next(32'h3004, rom(32'h3000), 32'h3000, 32'h3008, 1'b0); tick("post_rst");

    // Silent 32-bit wrap of the PC, caught by the range check
    jump = 2'b10; rs_value = 32'hFFFF_FFFC;
    expect_next(32'hFFFF_FFFC, rom(32'h3004), 32'h3004, 32'h300C, 1'b0); tick("wrap_set");
    jump = 2'b00;
    expect_next(32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1); tick("wrap0");
    expect_next(32'h0000_0004, 32'h0, 32'h0000_0000, 32'h0000_0008, 1'b1); tick("wrap1");

    chk32("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- F-stage PC engine of the 5-stage MIPS pipeline; the consumer of the D-stage controller's `jump[1:0]` and `PCEXop` decisions.
- Holds the PC register and computes next-PC (sequential, branch, J/JAL, JR/JALR), drives instruction-memory address.
- Owns the IF/ID pipeline register (instruction, PC, PC+8) feeding the D stage.
- Supports stall, IF/ID clear, and fetch-fault flagging (misaligned or out-of-range PC).

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
IMEM_WORDS, 4096, instruction memory depth in words; legal PC range is [RESET_PC, RESET_PC+4*IMEM_WORDS).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard stall: PC and IF/ID hold.
id_clear  input  1  load NOP bubble into IF/ID (ignored while stall=1).
jump  input  2  D-stage select: 00 seq, 01 imm-target, 10 register target, 11 reserved.
pcex_op  input  1  with jump=01: 1 = J/JAL pseudo-direct target, 0 = branch offset target.
d_imm26  input  26  instr[25:0] of the D-stage instruction (d_instr[25:0] fed back).
rs_value  input  32  forwarded GPR[rs] for JR/JALR.
imem_addr  output  32  current PC, combinational from PC register.
imem_rdata  input  32  asynchronous instruction-memory read data for imem_addr.
d_instr  output  32  IF/ID instruction.
d_pc  output  32  IF/ID PC.
d_pc8  output  32  IF/ID PC+8 (link value).
d_fetch_fault  output  1  IF/ID: instruction was fetched from an illegal PC.

Behaviour:
- Reset (sync): PC=RESET_PC; d_instr=0; d_pc=RESET_PC; d_pc8=RESET_PC+8; d_fetch_fault=0. Reset overrides stall and id_clear.
- Next-PC selection uses D-stage values and the current PC:
  - jump=00: PC+4.
  - jump=01, pcex_op=0: d_pc+4+(sext(d_imm26[15:0])<<2).
  - jump=01, pcex_op=1: {d_pc_plus4[31:28], d_imm26, 2'b00}, where d_pc_plus4 = d_pc+4.
  - jump=10: rs_value.
  - jump=11: treated as 00.
- All adds are 32-bit modulo; wrap at 2^32 is silent, and the fault check catches it.
- Delay slot: the instruction in F when D redirects is always loaded into IF/ID normally. There is no squash. The redirect takes effect on the next fetch, giving one delay slot with zero extra bubbles.
- When stall=1: PC and all IF/ID registers hold. jump is ignored, because the D instruction re-evaluates next cycle.
- When stall=0: PC <= next-PC.
  - IF/ID <= {fault ? 0 : imem_rdata, PC, PC+8, fault}.
  - If id_clear=1 instead: IF/ID <= {0, PC, PC+8, 0}. PC still advances.
- Fault condition: PC[1:0]!=0, PC<RESET_PC, or PC>=RESET_PC+4*IMEM_WORDS.
  - A faulting fetch injects NOP (0) into IF/ID with d_fetch_fault=1.
  - The PC keeps advancing; recovery is owned by the downstream exception logic.
- imem_addr equals PC at all times, including while stall=1 and during reset.
- Latency:
  - Instruction at PC appears on d_instr 1 cycle after PC is presented.
  - A redirect decided in D appears on imem_addr the next cycle.

Decomposition:
- Shared package `mips_defs`:
  - jump encodings JMP_SEQ=2'b00, JMP_IMM=2'b01, JMP_REG=2'b10.
  - NOP=32'h0, RESET_PC default.
- One natural sub-module: `npc_calc`, the combinational next-PC mux and adders. PC register, IF/ID register and fault check stay in the top.

Test Plan:
1. Reset, then 3 free-running cycles with jump=00 and ROM words A,B,C at 0x3000/4/8 -> imem_addr 0x3000, 0x3004, 0x3008, 0x300C; d_instr A,B,C lagging by one cycle; d_pc8 = d_pc+8.
2. BEQ taken: d_pc=0x3010, imm16=0xFFFC, jump=01, pcex_op=0 -> delay slot 0x3014 fetched, then imem_addr=0x3004.
3. JAL: d_pc=0x3020, d_imm26=0x0000C40, jump=01, pcex_op=1 -> after delay slot 0x3024, imem_addr=0x00003100.
4. JR: rs_value=0x3002, jump=10 -> imem_addr=0x3002; next cycle d_instr=0, d_fetch_fault=1; PC advances to 0x3006.
5. stall=1 held 2 cycles with jump=01 asserted -> PC and IF/ID unchanged. After release, id_clear=1 -> d_instr=0, d_fetch_fault=0, PC+4.
6. Reset asserted mid-stream with stall=1 and id_clear=1 -> next edge PC=0x3000, d_instr=0, d_pc=0x3000, d_pc8=0x3008.
